// File: rtl/axi_from_lite_buffered_if.sv
// Bus interfaces for the AXI-Lite to AXI bridge.
// axi_lite_channel: AXI-Lite five-channel bundle (no IDs, no bursts).
// axi_channel:      full AXI4 five-channel bundle with ID/user sidebands.
// The master modport drives requests and consumes responses; slave is the mirror.

interface axi_lite_channel #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64
);
    logic                      aw_valid;
    logic                      aw_ready;
    logic [ADDR_WIDTH-1:0]     aw_addr;
    logic [2:0]                aw_prot;

    logic                      w_valid;
    logic                      w_ready;
    logic [DATA_WIDTH-1:0]     w_data;
    logic [DATA_WIDTH/8-1:0]   w_strb;

    logic                      b_valid;
    logic                      b_ready;
    logic [1:0]                b_resp;

    logic                      ar_valid;
    logic                      ar_ready;
    logic [ADDR_WIDTH-1:0]     ar_addr;
    logic [2:0]                ar_prot;

    logic                      r_valid;
    logic                      r_ready;
    logic [DATA_WIDTH-1:0]     r_data;
    logic [1:0]                r_resp;

    modport master (
        output aw_valid, aw_addr, aw_prot, input aw_ready,
        output w_valid, w_data, w_strb, input w_ready,
        input  b_valid, b_resp, output b_ready,
        output ar_valid, ar_addr, ar_prot, input ar_ready,
        input  r_valid, r_data, r_resp, output r_ready
    );

    modport slave (
        input  aw_valid, aw_addr, aw_prot, output aw_ready,
        input  w_valid, w_data, w_strb, output w_ready,
        output b_valid, b_resp, input b_ready,
        input  ar_valid, ar_addr, ar_prot, output ar_ready,
        output r_valid, r_data, r_resp, input r_ready
    );
endinterface

interface axi_channel #(
    parameter int ID_WIDTH   = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64,
    parameter int USER_WIDTH = 1
);
    logic [ID_WIDTH-1:0]       aw_id;
    logic [ADDR_WIDTH-1:0]     aw_addr;
    logic [7:0]                aw_len;
    logic [2:0]                aw_size;
    logic [1:0]                aw_burst;
    logic                      aw_lock;
    logic [3:0]                aw_cache;
    logic [2:0]                aw_prot;
    logic [3:0]                aw_qos;
    logic [3:0]                aw_region;
    logic [USER_WIDTH-1:0]     aw_user;
    logic                      aw_valid;
    logic                      aw_ready;

    logic [DATA_WIDTH-1:0]     w_data;
    logic [DATA_WIDTH/8-1:0]   w_strb;
    logic                      w_last;
    logic [USER_WIDTH-1:0]     w_user;
    logic                      w_valid;
    logic                      w_ready;

    logic [ID_WIDTH-1:0]       b_id;
    logic [1:0]                b_resp;
    logic [USER_WIDTH-1:0]     b_user;
    logic                      b_valid;
    logic                      b_ready;

    logic [ID_WIDTH-1:0]       ar_id;
    logic [ADDR_WIDTH-1:0]     ar_addr;
    logic [7:0]                ar_len;
    logic [2:0]                ar_size;
    logic [1:0]                ar_burst;
    logic                      ar_lock;
    logic [3:0]                ar_cache;
    logic [2:0]                ar_prot;
    logic [3:0]                ar_qos;
    logic [3:0]                ar_region;
    logic [USER_WIDTH-1:0]     ar_user;
    logic                      ar_valid;
    logic                      ar_ready;

    logic [ID_WIDTH-1:0]       r_id;
    logic [DATA_WIDTH-1:0]     r_data;
    logic [1:0]                r_resp;
    logic                      r_last;
    logic [USER_WIDTH-1:0]     r_user;
    logic                      r_valid;
    logic                      r_ready;

    modport master (
        output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache,
               aw_prot, aw_qos, aw_region, aw_user, aw_valid, input aw_ready,
        output w_data, w_strb, w_last, w_user, w_valid, input w_ready,
        input  b_id, b_resp, b_user, b_valid, output b_ready,
        output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache,
               ar_prot, ar_qos, ar_region, ar_user, ar_valid, input ar_ready,
        input  r_id, r_data, r_resp, r_last, r_user, r_valid, output r_ready
    );

    modport slave (
        input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache,
               aw_prot, aw_qos, aw_region, aw_user, aw_valid, output aw_ready,
        input  w_data, w_strb, w_last, w_user, w_valid, output w_ready,
        output b_id, b_resp, b_user, b_valid, input b_ready,
        input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache,
               ar_prot, ar_qos, ar_region, ar_user, ar_valid, output ar_ready,
        output r_id, r_data, r_resp, r_last, r_user, r_valid, input r_ready
    );
endinterface

// File: rtl/axi_from_lite_buffered.sv
// AXI-Lite master to AXI slave bridge with registered request channels.
// - AW, AR and W each pass through an independent 2-entry skid buffer.
// - AW/AR issue is throttled by a per-direction outstanding counter.
// - B/R responses are combinational pass-through.
// Optional feature macro: AXI_FROM_LITE_ID_CHECK_EN
//   defined   -> responses with a foreign ID (or R without last) become SLVERR
//                and set the sticky resp_err flag.
//   undefined -> responses pass through untouched, resp_err is tied low.

// Two-entry registered FIFO used as the per-channel skid buffer.
// in_ready is low during reset and when both entries are occupied.
module axi_from_lite_buffered_skid #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             pop
);
    logic [WIDTH-1:0] mem [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic [1:0]       count;
    logic             push;
    logic             pop_ok;

    assign in_ready  = !rst && (count != 2'd2);
    assign out_valid = (count != 2'd0);
    assign out_data  = mem[rd_ptr];
    assign push      = in_valid && in_ready;
    assign pop_ok    = pop && out_valid;

    // Pointer/occupancy update; storage itself needs no reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= in_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop_ok) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, push} - {1'b0, pop_ok};
        end
    end
endmodule

module axi_from_lite_buffered #(
    parameter int          DATA_WIDTH      = 64,
    parameter int          AXI_ID          = 0,
    parameter int          MAX_OUTSTANDING = 4,
    parameter logic [3:0]  CACHE           = 4'h0,
    localparam int         CW              = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    axi_lite_channel.slave         master,
    axi_channel.master             slave,
    output logic [CW-1:0]          wr_outstanding,
    output logic [CW-1:0]          rd_outstanding,
    output logic                   resp_err
);
    localparam int AW      = $bits(master.aw_addr);
    localparam int SAW     = $bits(slave.aw_addr);
    localparam int MDW     = $bits(master.w_data);
    localparam int SDW     = $bits(slave.w_data);
    localparam int IDW     = $bits(slave.aw_id);
    localparam int SW      = DATA_WIDTH / 8;
    localparam logic [IDW-1:0] ID_CFG   = IDW'(AXI_ID);
    localparam logic [2:0]     SIZE_CFG = 3'($clog2(DATA_WIDTH / 8));
    localparam logic [CW-1:0]  CNT_MAX  = CW'(MAX_OUTSTANDING);

    if (AW != SAW) begin : g_addr_mismatch
        $fatal(1, "axi_from_lite_buffered: address width mismatch between ports");
    end
    if (MDW != DATA_WIDTH || SDW != DATA_WIDTH) begin : g_data_mismatch
        $fatal(1, "axi_from_lite_buffered: data width mismatch between ports");
    end
    if (MAX_OUTSTANDING < 1) begin : g_bad_limit
        $fatal(1, "axi_from_lite_buffered: MAX_OUTSTANDING must be >= 1");
    end

    logic [CW-1:0]      wr_cnt;
    logic [CW-1:0]      rd_cnt;

    logic               aw_ne;
    logic [AW+2:0]      aw_entry;
    logic               ar_ne;
    logic [AW+2:0]      ar_entry;
    logic               w_ne;
    logic [DATA_WIDTH+SW-1:0] w_entry;

    logic               aw_go;
    logic               ar_go;
    logic               aw_fire;
    logic               ar_fire;
    logic               b_fire;
    logic               r_fire;

    axi_from_lite_buffered_skid #(.WIDTH(AW + 3)) u_aw_buf (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (master.aw_valid),
        .in_ready  (master.aw_ready),
        .in_data   ({master.aw_addr, master.aw_prot}),
        .out_valid (aw_ne),
        .out_data  (aw_entry),
        .pop       (aw_fire)
    );

    axi_from_lite_buffered_skid #(.WIDTH(AW + 3)) u_ar_buf (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (master.ar_valid),
        .in_ready  (master.ar_ready),
        .in_data   ({master.ar_addr, master.ar_prot}),
        .out_valid (ar_ne),
        .out_data  (ar_entry),
        .pop       (ar_fire)
    );

    axi_from_lite_buffered_skid #(.WIDTH(DATA_WIDTH + SW)) u_w_buf (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (master.w_valid),
        .in_ready  (master.w_ready),
        .in_data   ({master.w_data, master.w_strb}),
        .out_valid (w_ne),
        .out_data  (w_entry),
        .pop       (slave.w_valid && slave.w_ready)
    );

    // Issue gating uses the registered count only, so valid never drops mid-handshake.
    assign aw_go   = !rst && aw_ne && (wr_cnt != CNT_MAX);
    assign ar_go   = !rst && ar_ne && (rd_cnt != CNT_MAX);
    assign aw_fire = aw_go && slave.aw_ready;
    assign ar_fire = ar_go && slave.ar_ready;
    assign b_fire  = slave.b_valid && master.b_ready;
    assign r_fire  = slave.r_valid && master.r_ready;

    // Write request channel.
    assign slave.aw_valid  = aw_go;
    assign slave.aw_addr   = aw_entry[AW+2:3];
    assign slave.aw_prot   = aw_entry[2:0];
    assign slave.aw_id     = ID_CFG;
    assign slave.aw_len    = 8'd0;
    assign slave.aw_size   = SIZE_CFG;
    assign slave.aw_burst  = 2'b01;
    assign slave.aw_lock   = 1'b0;
    assign slave.aw_cache  = CACHE;
    assign slave.aw_qos    = 4'd0;
    assign slave.aw_region = 4'd0;
    assign slave.aw_user   = '0;

    // Write data channel: not gated by wr_cnt, W may lead AW.
    assign slave.w_valid   = !rst && w_ne;
    assign slave.w_data    = w_entry[DATA_WIDTH+SW-1:SW];
    assign slave.w_strb    = w_entry[SW-1:0];
    assign slave.w_last    = 1'b1;
    assign slave.w_user    = '0;

    // Read request channel.
    assign slave.ar_valid  = ar_go;
    assign slave.ar_addr   = ar_entry[AW+2:3];
    assign slave.ar_prot   = ar_entry[2:0];
    assign slave.ar_id     = ID_CFG;
    assign slave.ar_len    = 8'd0;
    assign slave.ar_size   = SIZE_CFG;
    assign slave.ar_burst  = 2'b01;
    assign slave.ar_lock   = 1'b0;
    assign slave.ar_cache  = CACHE;
    assign slave.ar_qos    = 4'd0;
    assign slave.ar_region = 4'd0;
    assign slave.ar_user   = '0;

    // Response channels pass straight through.
    assign master.b_valid  = slave.b_valid;
    assign slave.b_ready   = master.b_ready;
    assign master.r_valid  = slave.r_valid;
    assign master.r_data   = slave.r_data;
    assign slave.r_ready   = master.r_ready;

    // Write outstanding count; decrement saturates at zero to absorb stray B beats.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_cnt <= '0;
        end else if (aw_fire && !b_fire) begin
            wr_cnt <= wr_cnt + CW'(1);
        end else if (b_fire && !aw_fire && (wr_cnt != '0)) begin
            wr_cnt <= wr_cnt - CW'(1);
        end
    end

    // Read outstanding count; every R beat closes one read.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_cnt <= '0;
        end else if (ar_fire && !r_fire) begin
            rd_cnt <= rd_cnt + CW'(1);
        end else if (r_fire && !ar_fire && (rd_cnt != '0)) begin
            rd_cnt <= rd_cnt - CW'(1);
        end
    end

    assign wr_outstanding = wr_cnt;
    assign rd_outstanding = rd_cnt;

`ifdef AXI_FROM_LITE_ID_CHECK_EN
    logic b_bad;
    logic r_bad;
    logic err_q;
    logic unused_sideband;

    assign b_bad = (slave.b_id != ID_CFG);
    assign r_bad = (slave.r_id != ID_CFG) || !slave.r_last;

    assign master.b_resp = b_bad ? 2'b10 : slave.b_resp;
    assign master.r_resp = r_bad ? 2'b10 : slave.r_resp;

    // Sticky protocol-error flag, set after an offending response handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if ((b_fire && b_bad) || (r_fire && r_bad)) begin
            err_q <= 1'b1;
        end
    end

    assign resp_err        = err_q;
    assign unused_sideband = ^{slave.b_user, slave.r_user};
`else
    logic unused_sideband;

    assign master.b_resp   = slave.b_resp;
    assign master.r_resp   = slave.r_resp;
    assign resp_err        = 1'b0;
    assign unused_sideband = ^{slave.b_id, slave.b_user, slave.r_id,
                               slave.r_last, slave.r_user};
`endif

endmodule
